// File: rtl/chain_programmer_pkg.sv
// Shared types for the configuration-chain programmer.
//   cp_state_t        : programmer FSM states
//   fu_program_data_t : one functional-unit slice of the downstream chain
//   CHAIN_LEN_DEFAULT : bits in a full chain (slice count x slice width)
package chain_programmer_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_WORD,
      SHIFT,
      DONE
   } cp_state_t;

   // One slice of the programming chain; the far end of the chain holds
   // the first bit shifted in, so field order here is shift order.
   typedef struct packed {
      logic [7:0] opcode;
      logic [7:0] operand_a;
      logic [7:0] operand_b;
      logic [7:0] flags;
   } fu_program_data_t;

   localparam int SLICE_COUNT       = 2;
   localparam int CHAIN_LEN_DEFAULT = SLICE_COUNT * $bits(fu_program_data_t);

endpackage

// File: rtl/chain_programmer.sv
// Serialises parallel configuration words into a 1-bit programming chain.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i, abort_i         open / cancel a programming session
//   word_valid_i, word_i     configuration word in (MSB shifted first)
//   word_ready_o             word accepted when valid && ready
//   program_en_o             chain shift enable (registered)
//   program_data_o           serial bit to chain head (registered)
//   busy_o                   session in progress
//   done_o                   one-cycle completion pulse (registered)
//   bits_sent_o              bits shifted in the current / last session
module chain_programmer
   import chain_programmer_pkg::*;
#(
   parameter int WORD_W    = 32,
   parameter int CHAIN_LEN = CHAIN_LEN_DEFAULT
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic              word_valid_i,
   input  logic [WORD_W-1:0] word_i,
   output logic              word_ready_o,
   output logic              program_en_o,
   output logic              program_data_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [15:0]       bits_sent_o
);

   localparam int                CNT_W    = $clog2(WORD_W + 1);
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WORD_W);
   localparam logic [15:0]       LEN16    = 16'(CHAIN_LEN);

   cp_state_t         state_reg, state_next;
   logic [WORD_W-1:0] shift_reg, shift_next;
   logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;   // bits of current word on the wire so far
   logic [15:0]       bits_sent_reg, bits_sent_next;
   logic              en_reg, en_next;
   logic              data_reg, data_next;
   logic              done_reg, done_next;

   logic last_bit;
   logic chain_full;
   logic word_ready;
   logic take_word;

   // The bit currently on program_data_o is already counted in
   // bits_sent_reg, so "chain_full" means the last chain bit is on the wire.
   assign last_bit   = (bit_cnt_reg == LAST_BIT);
   assign chain_full = (bits_sent_reg == LEN16);
   assign word_ready = (state_reg == WAIT_WORD) ||
                       ((state_reg == SHIFT) && last_bit && !chain_full);
   assign take_word  = word_ready && word_valid_i;

   always_comb begin
      state_next     = state_reg;
      shift_next     = shift_reg;
      bit_cnt_next   = bit_cnt_reg;
      bits_sent_next = bits_sent_reg;
      en_next        = 1'b0;
      data_next      = 1'b0;
      done_next      = 1'b0;

      if (abort_i) begin
         state_next = IDLE;
      end else begin
         unique case (state_reg)
            IDLE: begin
               if (start_i) begin
                  state_next     = WAIT_WORD;
                  bits_sent_next = 16'd0;
               end
            end
            WAIT_WORD, SHIFT: begin
               if ((state_reg == SHIFT) && chain_full) begin
                  // Any unsent bits of the final word are simply dropped.
                  state_next = DONE;
                  done_next  = 1'b1;
               end else if (take_word) begin
                  // MSB goes straight to the output register so it appears
                  // the cycle after acceptance, with no enable gap.
                  state_next     = SHIFT;
                  en_next        = 1'b1;
                  data_next      = word_i[WORD_W-1];
                  shift_next     = word_i << 1;
                  bit_cnt_next   = CNT_W'(1);
                  bits_sent_next = bits_sent_reg + 16'd1;
               end else if (state_reg == SHIFT && last_bit) begin
                  state_next = WAIT_WORD;
               end else if (state_reg == SHIFT) begin
                  en_next        = 1'b1;
                  data_next      = shift_reg[WORD_W-1];
                  shift_next     = shift_reg << 1;
                  bit_cnt_next   = bit_cnt_reg + CNT_W'(1);
                  bits_sent_next = bits_sent_reg + 16'd1;
               end
            end
            DONE: begin
               state_next = IDLE;
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg     <= IDLE;
         shift_reg     <= '0;
         bit_cnt_reg   <= '0;
         bits_sent_reg <= '0;
         en_reg        <= 1'b0;
         data_reg      <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         shift_reg     <= shift_next;
         bit_cnt_reg   <= bit_cnt_next;
         bits_sent_reg <= bits_sent_next;
         en_reg        <= en_next;
         data_reg      <= data_next;
         done_reg      <= done_next;
      end
   end

   assign word_ready_o   = word_ready;
   assign program_en_o   = en_reg;
   assign program_data_o = data_reg;
   assign busy_o         = (state_reg == WAIT_WORD) || (state_reg == SHIFT);
   assign done_o         = done_reg;
   assign bits_sent_o    = bits_sent_reg;

endmodule

// File: tb/tb_chain_programmer.sv
// Bench for chain_programmer: two instances (8-bit words, 16- and 20-bit
// chains), a queue-based session model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_chain_programmer;

   localparam int W    = 8;
   localparam int LEN0 = 16;
   localparam int LEN1 = 20;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         start_s [2];
   logic         abort_s [2];
   logic         valid_s [2];
   logic [W-1:0] word_s  [2];
   logic         ready_o [2];
   logic         en_o    [2];
   logic         data_o  [2];
   logic         busy_o  [2];
   logic         done_o  [2];
   logic [15:0]  bits_o  [2];

   chain_programmer #(.WORD_W(W), .CHAIN_LEN(LEN0)) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start_s[0]), .abort_i(abort_s[0]),
      .word_valid_i(valid_s[0]), .word_i(word_s[0]), .word_ready_o(ready_o[0]),
      .program_en_o(en_o[0]), .program_data_o(data_o[0]), .busy_o(busy_o[0]),
      .done_o(done_o[0]), .bits_sent_o(bits_o[0]));

   chain_programmer #(.WORD_W(W), .CHAIN_LEN(LEN1)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start_s[1]), .abort_i(abort_s[1]),
      .word_valid_i(valid_s[1]), .word_i(word_s[1]), .word_ready_o(ready_o[1]),
      .program_en_o(en_o[1]), .program_data_o(data_o[1]), .busy_o(busy_o[1]),
      .done_o(done_o[1]), .bits_sent_o(bits_o[1]));

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst%0d got %0h expected %0h (cycle %0d)", name, k, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Session phase: 0 idle, 1 waiting for a word, 2 shifting, 3 done.
   // m_q holds the not-yet-emitted bits of the current word.
   int m_state [2];
   bit m_q     [2][$];
   int m_bits  [2];
   bit m_en    [2];
   bit m_data  [2];
   bit m_done  [2];

   function automatic int lenof(int k);
      return (k == 0) ? LEN0 : LEN1;
   endfunction

   function automatic bit m_ready(int k);
      return (m_state[k] == 1) ||
             (m_state[k] == 2 && m_q[k].size() == 0 && m_bits[k] < lenof(k));
   endfunction

   task automatic m_emit(int k);
      m_data[k] = m_q[k].pop_front();
      m_en[k]   = 1'b1;
      m_bits[k] = m_bits[k] + 1;
   endtask

   task automatic m_load(int k);
      m_q[k].delete();
      for (int b = W - 1; b >= 0; b--) m_q[k].push_back(word_s[k][b]);
      m_state[k] = 2;
      m_emit(k);
   endtask

   task automatic m_step(int k);
      m_en[k] = 1'b0; m_data[k] = 1'b0; m_done[k] = 1'b0;
      if (abort_s[k]) m_state[k] = 0;
      else case (m_state[k])
         0: if (start_s[k]) begin m_state[k] = 1; m_bits[k] = 0; end
         1: if (valid_s[k]) m_load(k);
         2: begin
            if (m_bits[k] == lenof(k)) begin m_state[k] = 3; m_done[k] = 1'b1; end
            else if (m_q[k].size() == 0) begin
               if (valid_s[k]) m_load(k); else m_state[k] = 1;
            end else m_emit(k);
         end
         default: m_state[k] = 0;
      endcase
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_state[k] = 0; m_q[k].delete(); m_bits[k] = 0;
            m_en[k] = 1'b0; m_data[k] = 1'b0; m_done[k] = 1'b0;
         end
      end else begin
         for (int k = 0; k < 2; k++) m_step(k);
      end
   end

   // ---------------- per-session statistics / chain model ----------------
   int          st_en    [2];
   int          st_first [2];
   int          st_last  [2];
   int          st_done  [2];
   int          done_total = 0;
   logic [31:0] chain_v  [2];   // downstream chain: head bit enters at LSB

   task automatic clear_stats(int k);
      st_en[k] = 0; st_first[k] = -1; st_last[k] = -1; st_done[k] = -1;
      chain_v[k] = '0;
   endtask

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < 2; k++) begin
            chk("en", k, 32'(en_o[k]), 32'(m_en[k]));
            if (m_en[k]) chk("data", k, 32'(data_o[k]), 32'(m_data[k]));
            chk("ready", k, 32'(ready_o[k]), 32'(m_ready(k)));
            chk("busy", k, 32'(busy_o[k]), 32'(m_state[k] == 1 || m_state[k] == 2));
            chk("done", k, 32'(done_o[k]), 32'(m_done[k]));
            chk("bits", k, 32'(bits_o[k]), 32'(m_bits[k]));
            if (en_o[k]) begin
               st_en[k]++;
               if (st_first[k] < 0) st_first[k] = cyc;
               st_last[k] = cyc;
               chain_v[k] = {chain_v[k][30:0], data_o[k]};
            end
            if (done_o[k]) begin
               st_done[k] = cyc;
               done_total++;
            end
         end
      end
   end

   // ---------------- stimulus helpers (called just after a posedge) ----------------
   task automatic do_start(int k);
      clear_stats(k);
      start_s[k] = 1'b1;
      @(posedge clk); #1;
      start_s[k] = 1'b0;
   endtask

   task automatic send_word(int k, logic [W-1:0] w);
      bit ok = 1'b0;
      word_s[k]  = w;
      valid_s[k] = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ready_o[k]) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      chk("accept_in_time", k, 32'(ok), 32'd1);
   endtask

   task automatic wait_done(int k);
      bit ok = 1'b0;
      valid_s[k] = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done_o[k]) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      chk("done_in_time", k, 32'(ok), 32'd1);
   endtask

   task automatic check_stream(string tag, int k, int nbits, int gap, logic [31:0] stream);
      chk({tag, "_en_cycles"}, k, 32'(st_en[k]), 32'(nbits));
      chk({tag, "_en_gap"}, k, 32'((st_last[k] - st_first[k] + 1) - st_en[k]), 32'(gap));
      chk({tag, "_stream"}, k, chain_v[k], stream);
      chk({tag, "_done_after_last"}, k, 32'(st_done[k]), 32'(st_last[k] + 1));
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         start_s[k] = 1'b0; abort_s[k] = 1'b0; valid_s[k] = 1'b0; word_s[k] = '0;
         clear_stats(k);
      end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_en", k, 32'(en_o[k]), 32'd0);
         chk("rst_data", k, 32'(data_o[k]), 32'd0);
         chk("rst_ready", k, 32'(ready_o[k]), 32'd0);
         chk("rst_busy", k, 32'(busy_o[k]), 32'd0);
         chk("rst_done", k, 32'(done_o[k]), 32'd0);
         chk("rst_bits", k, 32'(bits_o[k]), 32'd0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Back-to-back 0xA5, 0x3C into the 16-bit chain.
      do_start(0);
      send_word(0, 8'hA5);
      send_word(0, 8'h3C);
      wait_done(0);
      check_stream("b2b", 0, 16, 0, 32'h0000A53C);
      chk("b2b_slice_far", 0, 32'(chain_v[0][15:8]), 32'h000000A5);
      chk("b2b_slice_near", 0, 32'(chain_v[0][7:0]), 32'h0000003C);
      chk("b2b_bits", 0, 32'(bits_o[0]), 32'd16);

      // Same words with the second one withheld for 5 cycles.
      do_start(0);
      send_word(0, 8'hA5);
      valid_s[0] = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      send_word(0, 8'h3C);
      wait_done(0);
      check_stream("gap", 0, 16, 5, 32'h0000A53C);

      // 0xFF, 0x00, 0xF0 into the 20-bit chain; low nibble of 0xF0 dropped.
      do_start(1);
      send_word(1, 8'hFF);
      send_word(1, 8'h00);
      send_word(1, 8'hF0);
      wait_done(1);
      check_stream("trunc", 1, 20, 0, 32'h000FF00F);
      chk("trunc_bits", 1, 32'(bits_o[1]), 32'd20);

      // Abort while the fifth bit is on the wire, then restart.
      do_start(0);
      send_word(0, 8'hA5);
      valid_s[0] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      abort_s[0] = 1'b1;
      @(negedge clk);
      chk("abort_at_bit", 0, 32'(bits_o[0]), 32'd5);
      @(posedge clk); #1;
      abort_s[0] = 1'b0;
      @(negedge clk);
      chk("abort_en", 0, 32'(en_o[0]), 32'd0);
      chk("abort_busy", 0, 32'(busy_o[0]), 32'd0);
      chk("abort_bits", 0, 32'(bits_o[0]), 32'd5);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort_no_done", 0, 32'(done_o[0]), 32'd0);
      end
      @(posedge clk); #1;
      do_start(0);
      @(negedge clk);
      chk("restart_bits", 0, 32'(bits_o[0]), 32'd0);
      @(posedge clk); #1;
      send_word(0, 8'hA5);
      send_word(0, 8'h3C);
      wait_done(0);
      check_stream("restart", 0, 16, 0, 32'h0000A53C);

      // Asynchronous reset mid-shift.
      do_start(0);
      send_word(0, 8'hA5);
      valid_s[0] = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_en", 0, 32'(en_o[0]), 32'd0);
      chk("async_rst_data", 0, 32'(data_o[0]), 32'd0);
      chk("async_rst_busy", 0, 32'(busy_o[0]), 32'd0);
      chk("async_rst_ready", 0, 32'(ready_o[0]), 32'd0);
      chk("async_rst_bits", 0, 32'(bits_o[0]), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // start_i while busy must not clear the bit count.
      do_start(0);
      send_word(0, 8'hA5);
      repeat (2) @(posedge clk);
      #1;
      start_s[0] = 1'b1;
      @(posedge clk); #1;
      start_s[0] = 1'b0;
      @(negedge clk);
      chk("start_ignored_bits", 0, 32'(bits_o[0]), 32'd4);
      chk("start_ignored_busy", 0, 32'(busy_o[0]), 32'd1);
      @(posedge clk); #1;
      send_word(0, 8'h3C);
      wait_done(0);
      chk("start_ignored_stream", 0, chain_v[0], 32'h0000A53C);

      // Randomized traffic on both instances, checked by the model each cycle.
      done_total = 0;
      for (int c = 0; c < 4000; c++) begin
         for (int k = 0; k < 2; k++) begin
            start_s[k] = ($urandom % 6) == 0;
            abort_s[k] = ($urandom % 60) == 0;
            valid_s[k] = ($urandom % 3) != 0;
            word_s[k]  = W'($urandom);
         end
         @(posedge clk); #1;
      end
      for (int k = 0; k < 2; k++) begin
         start_s[k] = 1'b0; abort_s[k] = 1'b0; valid_s[k] = 1'b0;
      end
      repeat (3) @(posedge clk);
      chk("random_sessions_completed", 0, 32'(done_total > 0), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/chain_programmer.md
CHAIN_PROGRAMMER -- requirements
Module: chain_programmer

Interface
REQ-001 The module SHALL have parameter WORD_W, default 32, meaning the width of each parallel configuration word.
REQ-002 The module SHALL have parameter CHAIN_LEN, default 64, meaning the total bits to shift into the downstream programming chain (1..2^16-1).
REQ-003 The module SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be clk_i and rst_ni, and reset polarity and synchronicity are fixed.
REQ-004 Ports SHALL be:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- start_i  in  1  begin a programming session
- abort_i  in  1  cancel the session
- word_valid_i  in  1  word_i valid
- word_i  in  WORD_W  configuration word, transmitted MSB first
- word_ready_o  out  1  word accepted when valid && ready
- program_en_o  out  1  chain shift enable
- program_data_o  out  1  serial bit to the chain head
- busy_o  out  1  session in progress
- done_o  out  1  one-cycle pulse on session completion
- bits_sent_o  out  16  bits shifted in the current or last session

Function
REQ-005 The FSM SHALL have exactly these states: IDLE, WAIT_WORD, SHIFT, DONE.
REQ-006 IDLE: start_i=1 -> WAIT_WORD and clear bits_sent_o to 0; start_i is ignored in every other state.
REQ-007 WAIT_WORD: word_ready_o=1; on word_valid_i=1 load the shift register with word_i -> SHIFT.
REQ-008 SHIFT: each cycle drives program_en_o=1 and program_data_o=shift_reg[WORD_W-1], left-shifts the register, and increments bits_sent_o.
REQ-009 Latency: a word accepted at the cycle-N edge SHALL present its MSB on program_data_o with program_en_o=1 during cycle N+1.
REQ-010 In SHIFT, when the current bit is the word's last bit and bits remain, word_ready_o SHALL be 1 (gapless back-to-back).
- Valid word on that cycle: load it; stay in SHIFT with no en gap.
- No valid word on that cycle: go to WAIT_WORD.
REQ-011 While in WAIT_WORD, program_en_o SHALL be 0 so the chain holds its contents.
REQ-012 When bits_sent_o reaches CHAIN_LEN, the FSM SHALL enter DONE.
- Unsent bits of the final word are discarded.
- word_ready_o SHALL NOT assert on that final bit.
REQ-013 DONE SHALL last one cycle with done_o=1, then enter IDLE.
REQ-014 busy_o SHALL be 1 in WAIT_WORD and SHIFT, and 0 in IDLE and DONE.
REQ-015 abort_i=1 in any state SHALL force IDLE on the next edge: program_en_o=0, no done_o pulse, bits_sent_o held.
- abort_i SHALL take priority over a simultaneous handshake or completion.
REQ-016 program_en_o, program_data_o and done_o SHALL be registered outputs.
REQ-017 word_ready_o SHALL be a combinational decode of state and bit counters.
REQ-018 bits_sent_o SHALL NOT wrap, because CHAIN_LEN is bounded below 2^16.

Reset
REQ-019 When rst_ni=0, the block SHALL asynchronously enter IDLE.
REQ-020 Reset values SHALL be 0 for word_ready_o, program_en_o, program_data_o, busy_o, done_o, bits_sent_o and the shift register.
REQ-021 Reset asserted mid-SHIFT SHALL drop program_en_o immediately, leaving the chain partially programmed; recovery is a new start_i.

Structure
REQ-022 The FSM state enum (cp_state_t) and the default CHAIN_LEN constant SHALL live in the shared types package.
REQ-023 CHAIN_LEN SHALL be derivable there as slice count times $bits(fu_program_data_t).
REQ-024 The block SHALL be a single module with no sub-modules; the shift register and counters are inline.

Verification
REQ-025 With WORD_W=8 and CHAIN_LEN=16, start, then words 0xA5 and 0x3C back-to-back SHALL give:
- en high for exactly 16 consecutive cycles;
- serial stream 1010_0101_0011_1100;
- done_o pulse one cycle after the last bit.
REQ-026 With WORD_W=8 and CHAIN_LEN=20, sending 0xFF, 0x00, 0xF0 SHALL give:
- 20 bits emitted: 8 ones, 8 zeros, 4 ones;
- the last 4 bits of 0xF0 discarded;
- bits_sent_o=20.
REQ-027 Withholding word_valid_i for 5 cycles between words SHALL hold en=0 for those 5 cycles, with the stream otherwise identical to REQ-025.
REQ-028 Asserting abort_i at bit 5 of 16 SHALL give: en=0 next cycle, no done_o, bits_sent_o=5, IDLE; a following start SHALL restart from 0.
REQ-029 Pulsing rst_ni low mid-SHIFT SHALL drive all outputs 0 asynchronously; start_i during busy SHALL be ignored (bits_sent_o is not cleared).
REQ-030 A bench model of a 2-slice chain SHALL hold exactly the stream of REQ-025 after done_o.
